decoder_n_scan: RTL and testbench



---
 rtl/decoder_n_scan.sv | 91 +++++++++
 tb/tb_decoder_n_scan.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/decoder_n_scan.sv
// Registered N-to-2^N one-hot decoder with direct and free-running scan modes.
// Optional DECODER_BLANK_EN blanks Y for one cycle at the start of every scan step.
module decoder_n_scan #(
  parameter int N     = 3,
  parameter int DWELL = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              E,
  input  logic              mode,
  input  logic [N-1:0]      A,
  output logic [(2**N)-1:0] Y,
  output logic [N-1:0]      idx,
  output logic              wrap
);

  localparam int W  = 2 ** N;
  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW-1:0] DCNT_LAST = DW'(DWELL - 1);

`ifdef DECODER_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  typedef enum logic {S_DIRECT, S_SCAN} state_t;

  state_t        state, state_nx;
  logic [DW-1:0] dcnt, dcnt_nx;
  logic [N-1:0]  idx_nx, idx_inc;
  logic [W-1:0]  y_nx;
  logic          wrap_nx;

  function automatic logic [W-1:0] one_hot(input logic [N-1:0] i);
    one_hot = {{(W-1){1'b0}}, 1'b1} << i;
  endfunction

  assign idx_inc = idx + N'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_DIRECT;
      dcnt  <= '0;
      idx   <= '0;
      Y     <= '0;
      wrap  <= 1'b0;
    end else begin
      state <= state_nx;
      dcnt  <= dcnt_nx;
      idx   <= idx_nx;
      Y     <= y_nx;
      wrap  <= wrap_nx;
    end
  end

  // Mode changes take priority over stepping; A is only sampled on direct or entry edges.
  always_comb begin
    state_nx = state;
    dcnt_nx  = dcnt;
    idx_nx   = idx;
    y_nx     = '0;
    wrap_nx  = 1'b0;
    if (!mode) begin
      state_nx = S_DIRECT;
      idx_nx   = A;
      dcnt_nx  = '0;
      y_nx     = E ? one_hot(A) : '0;
    end else if (state == S_DIRECT) begin
      state_nx = S_SCAN;
      idx_nx   = A;
      dcnt_nx  = '0;
      y_nx     = E ? one_hot(A) : '0;
    end else if (E) begin
      if (dcnt != DCNT_LAST) begin
        dcnt_nx = dcnt + DW'(1);
        y_nx    = one_hot(idx);
      end else begin
        dcnt_nx = '0;
        idx_nx  = idx_inc;
        y_nx    = one_hot(idx_inc);
        wrap_nx = (idx == {N{1'b1}});
      end
    end
    // Anti-ghosting: one dark cycle whenever a scan step (or scan entry) leaves dcnt at 0.
    if (BLANK && state_nx == S_SCAN && dcnt_nx == '0) begin
      y_nx = '0;
    end
  end

endmodule

// File: tb/tb_decoder_n_scan.sv
// Scoreboard bench for decoder_n_scan (N=3, DWELL=4): stimulus pushes expectations,
// a monitor pops and compares one entry per clock edge.
module tb_decoder_n_scan;

  localparam int DWELL = 4;
`ifdef DECODER_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] y;
    logic [2:0] idx;
    logic       wrap;
    logic [15:0] vec;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       E;
  logic       mode;
  logic [2:0] A;
  logic [7:0] Y;
  logic [2:0] idx;
  logic       wrap;

  exp_t exp_q[$];
  int   check_cnt = 0;
  int   pass_cnt  = 0;
  int   vec_cnt   = 0;

  decoder_n_scan #(.N(3), .DWELL(DWELL)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .E    (E),
    .mode (mode),
    .A    (A),
    .Y    (Y),
    .idx  (idx),
    .wrap (wrap)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input int vec, input logic [7:0] act,
                              input logic [7:0] req);
    check_cnt++;
    if (act === req) pass_cnt++;
    else $display("[TB] FAIL %s (vector %0d): got %h, required %h", name, vec, act, req);
  endtask

  task automatic apply_stimulus(input logic m, input logic e, input logic [2:0] a,
                                input logic [7:0] ey, input logic [2:0] ei, input logic ew);
    exp_t x;
    @(negedge clk);
    mode = m;
    E    = e;
    A    = a;
    x.y    = ey;
    x.idx  = ei;
    x.wrap = ew;
    x.vec  = 16'(vec_cnt);
    vec_cnt++;
    exp_q.push_back(x);
  endtask

  // k counts enabled scan cycles since the entry edge (k=0 is the entry edge).
  task automatic scan_step(input int start, input int k, input logic [2:0] a);
    logic [2:0] ei;
    logic [7:0] ey;
    logic       ew;
    ei = 3'((start + k / DWELL) % 8);
    ey = (BLANK && (k % DWELL == 0)) ? 8'h00 : (8'h01 << ei);
    ew = (k > 0) && (k % DWELL == 0) && (ei == 3'd0);
    apply_stimulus(1'b1, 1'b1, a, ey, ei, ew);
  endtask

  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        check_output("Y", int'(x.vec), Y, x.y);
        check_output("idx", int'(x.vec), {5'b0, idx}, {5'b0, x.idx});
        check_output("wrap", int'(x.vec), {7'b0, wrap}, {7'b0, x.wrap});
      end
    end
  end

  initial begin
    logic [7:0] y_tab [8];
    y_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    rst_n = 1'b0;
    mode  = 1'b0;
    E     = 1'b0;
    A     = 3'd0;
    #12;
    check_output("reset Y", -1, Y, 8'h00);
    check_output("reset idx", -1, {5'b0, idx}, 8'h00);
    check_output("reset wrap", -1, {7'b0, wrap}, 8'h00);
    rst_n = 1'b1;

    for (int a = 0; a < 8; a++) apply_stimulus(1'b0, 1'b1, 3'(a), y_tab[a], 3'(a), 1'b0);
    apply_stimulus(1'b0, 1'b0, 3'd5, 8'h00, 3'd5, 1'b0);

    // Scan from 6 through rollover; A is scrambled after entry and must be ignored.
    for (int k = 0; k < 22; k++) scan_step(6, k, (k == 0) ? 3'd6 : 3'(k * 3));
    for (int p = 0; p < 5; p++) apply_stimulus(1'b1, 1'b0, 3'(p), 8'h00, 3'd3, 1'b0);
    for (int k = 22; k < 25; k++) scan_step(6, k, 3'(k));

    apply_stimulus(1'b0, 1'b1, 3'd1, 8'h02, 3'd1, 1'b0);

    // Re-entry at 7: dcnt restarts; pause lands on the step-due edge.
    for (int k = 0; k < 4; k++) scan_step(7, k, (k == 0) ? 3'd7 : 3'd2);
    for (int p = 0; p < 2; p++) apply_stimulus(1'b1, 1'b0, 3'd4, 8'h00, 3'd7, 1'b0);
    for (int k = 4; k < 41; k++) scan_step(7, k, 3'(k));

    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_output("async reset Y", -2, Y, 8'h00);
    check_output("async reset idx", -2, {5'b0, idx}, 8'h00);
    check_output("async reset wrap", -2, {7'b0, wrap}, 8'h00);
    mode = 1'b0;
    E    = 1'b1;
    A    = 3'd2;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    apply_stimulus(1'b0, 1'b1, 3'd2, 8'h04, 3'd2, 1'b0);
    apply_stimulus(1'b0, 1'b1, 3'd7, 8'h80, 3'd7, 1'b0);

    repeat (3) @(posedge clk);
    #2;
    check_output("queue drained", -3, 8'(exp_q.size()), 8'h00);
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
